// File: rtl/lcd_controller_if.sv
// CPU-side bus of the HD44780 sequencer: write data, combinational read data,
// register select and the chip/write strobes.
interface lcd_controller_if;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [1:0] register_select;
  logic       chip_en;
  logic       wrt_en;

  modport master (
    output data_in, register_select, chip_en, wrt_en,
    input  data_out
  );

  modport slave (
    input  data_in, register_select, chip_en, wrt_en,
    output data_out
  );
endinterface

// File: rtl/lcd_controller.sv
// HD44780 character-LCD sequencer: CPU bytes are queued in a FIFO and replayed with
// setup / enable-pulse / execution-wait timing. Optional LCD_INIT_SEQ_EN adds a power-up init sequence.
module lcd_controller #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 3,
  parameter int PULSE_CYCLES = 12,
  parameter int EXEC_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 80000
) (
  input  logic             clk,
  input  logic             reset,
  lcd_controller_if.slave  bus,
  output logic [7:0]       lcd_data,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_en,
  output logic             busy
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYCLES);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT
  } state_t;

`ifdef LCD_INIT_SEQ_EN
  localparam state_t     RESET_STATE = ST_INIT;
  localparam logic [2:0] INIT_LEN    = 3'd4;
`else
  localparam state_t     RESET_STATE = ST_IDLE;
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [8:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             overflow_reg, overflow_next;

  logic             lcd_rs_reg, lcd_en_reg;
  logic [7:0]       lcd_data_reg;
  logic             init_done;

  logic             push_req, push_ok, pop, status_rd;
  logic             fifo_empty, fifo_full;
  logic             take_fifo, load, load_rs;
  logic [7:0]       load_data;
  logic [8:0]       head;
  logic             clear_cmd, cnt_last;

  assign push_req   = bus.chip_en & bus.wrt_en & ~bus.register_select[1];
  assign status_rd  = bus.chip_en & ~bus.wrt_en & (bus.register_select == 2'd2);
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_COUNT);
  // A pop on the same edge frees the slot the push needs, so a full FIFO still accepts it.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign head       = fifo_mem[rd_ptr_reg];
  assign cnt_last   = (cnt_reg == CNT_ONE);

  // Clear (0x01) and return-home (0x02/0x03) are the slow instructions.
  assign clear_cmd  = ~lcd_rs_reg & (lcd_data_reg[7:2] == 6'd0) & (lcd_data_reg[1:0] != 2'd0);

  // Setting wins over the read-clear on the same edge.
  assign overflow_next = (push_req & ~push_ok) | (overflow_reg & ~status_rd);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= {bus.register_select[0], bus.data_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      overflow_reg <= overflow_next;
    end
  end

`ifdef LCD_INIT_SEQ_EN
  logic [2:0] init_idx_reg, init_idx_next;
  logic       init_done_reg, init_done_next;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_idx_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      init_idx_reg  <= init_idx_next;
      init_done_reg <= init_done_next;
    end
  end

  assign init_done = init_done_reg;
`else
  assign init_done = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    take_fifo  = 1'b0;
    load       = 1'b0;
    load_rs    = 1'b0;
    load_data  = 8'h00;
    pop        = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    init_idx_next  = init_idx_reg;
    init_done_next = init_done_reg;
`endif
    case (state_reg)
      ST_IDLE: take_fifo = 1'b1;
`ifdef LCD_INIT_SEQ_EN
      // Power-up delay counts up from the reset value of zero.
      ST_INIT: begin
        if (cnt_reg == CLEAR_LOAD - CNT_ONE) begin
          load          = 1'b1;
          load_data     = init_byte(init_idx_reg[1:0]);
          init_idx_next = init_idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
`endif
      ST_SETUP: begin
        if (cnt_last) begin
          state_next = ST_PULSE;
          cnt_next   = PULSE_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_last) begin
          state_next = ST_WAIT;
          cnt_next   = clear_cmd ? CLEAR_LOAD : EXEC_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (cnt_last) begin
          state_next = ST_IDLE;
`ifdef LCD_INIT_SEQ_EN
          if (init_idx_reg != INIT_LEN) begin
            load          = 1'b1;
            load_data     = init_byte(init_idx_reg[1:0]);
            init_idx_next = init_idx_reg + 3'd1;
          end else begin
            init_done_next = 1'b1;
            take_fifo      = 1'b1;
          end
`else
          take_fifo = 1'b1;
`endif
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Popping straight out of WAIT keeps back-to-back bytes free of a gap cycle.
    if (take_fifo && !fifo_empty) begin
      pop       = 1'b1;
      load      = 1'b1;
      load_rs   = head[8];
      load_data = head[7:0];
    end
    if (load) begin
      state_next = ST_SETUP;
      cnt_next   = SETUP_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= RESET_STATE;
      cnt_reg      <= '0;
      lcd_rs_reg   <= 1'b0;
      lcd_data_reg <= 8'h00;
      lcd_en_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      lcd_en_reg <= (state_next == ST_PULSE);
      if (load) begin
        lcd_rs_reg   <= load_rs;
        lcd_data_reg <= load_data;
      end
    end
  end

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.register_select == 2'd2) begin
      bus.data_out = {init_done, 4'b0000, overflow_reg, fifo_full, busy};
    end
  end

  assign lcd_data = lcd_data_reg;
  assign lcd_rs   = lcd_rs_reg;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_reg;
  assign busy     = (state_reg != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with SETUP=2 PULSE=4 EXEC=8 CLEAR=20 DEPTH=4.
// Edge numbers count rising edges after the one that captured the CPU write.
module tb_lcd_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, busy;

  int errors = 0;
  int checks = 0;

`ifdef LCD_INIT_SEQ_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  localparam logic [7:0] STATUS_AFTER_RESET = INIT_EN ? 8'h01 : 8'h80;

  lcd_controller_if bus_if();

  lcd_controller #(
    .FIFO_DEPTH  (4),
    .SETUP_CYCLES(2),
    .PULSE_CYCLES(4),
    .EXEC_CYCLES (8),
    .CLEAR_CYCLES(20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_en  (lcd_en),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    int         en_start;
    int         en_len;
    int         idle_edge;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] cap [8];
  int         ncap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_if.chip_en         = 1'b0;
    bus_if.wrt_en          = 1'b0;
    bus_if.register_select = 2'd0;
    bus_if.data_in         = 8'h00;
  endtask

  task automatic cpu_write(input logic [1:0] sel, input logic [7:0] data);
    bus_if.chip_en         = 1'b1;
    bus_if.wrt_en          = 1'b1;
    bus_if.register_select = sel;
    bus_if.data_in         = data;
    tick();
    idle_bus();
  endtask

  // commit=1 lets the read strobe reach a clock edge (clears overflow).
  task automatic read_status(output logic [7:0] value, input bit commit);
    bus_if.chip_en         = 1'b1;
    bus_if.wrt_en          = 1'b0;
    bus_if.register_select = 2'd2;
    #1;
    value = bus_if.data_out;
    if (commit) begin
      @(posedge clk);
      #1;
    end
    idle_bus();
  endtask

  // Records lcd_data at every rising lcd_en until the controller goes idle.
  task automatic collect(input int max_edges);
    logic prev_en;
    prev_en = lcd_en;
    ncap = 0;
    for (int e = 0; e < max_edges; e++) begin
      tick();
      if (lcd_en && !prev_en) begin
        if (ncap < 8) cap[ncap] = lcd_data;
        ncap++;
      end
      prev_en = lcd_en;
      if (!busy && !lcd_en) break;
    end
  endtask

  initial begin
    logic [7:0] st;
    int en_start, en_len, idle_e;

    vecs[0] = '{2'd1, 8'h41, 3, 4, 15};
    vecs[1] = '{2'd0, 8'h01, 3, 4, 27};
    vecs[2] = '{2'd0, 8'h02, 3, 4, 27};
    vecs[3] = '{2'd0, 8'h03, 3, 4, 27};
    vecs[4] = '{2'd0, 8'h00, 3, 4, 15};
    vecs[5] = '{2'd0, 8'h04, 3, 4, 15};
    vecs[6] = '{2'd1, 8'h01, 3, 4, 15};
    vecs[7] = '{2'd0, 8'h38, 3, 4, 15};

    idle_bus();
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset lcd_en", lcd_en, 0);
    check("reset lcd_rs", lcd_rs, 0);
    check("reset lcd_data", lcd_data, 8'h00);
    check("reset lcd_rw", lcd_rw, 0);
    check("reset busy", busy, INIT_EN);
    reset = 1'b1;
    tick();
    read_status(st, 1'b0);
    check("status after reset", st, STATUS_AFTER_RESET);

`ifdef LCD_INIT_SEQ_EN
    cpu_write(2'd1, 8'h48);
    collect(600);
    check("init byte count", ncap, 5);
    check("init byte0", cap[0], 8'h38);
    check("init byte1", cap[1], 8'h0C);
    check("init byte2", cap[2], 8'h01);
    check("init byte3", cap[3], 8'h06);
    check("init queued data", cap[4], 8'h48);
    read_status(st, 1'b0);
    check("status after init", st, 8'h80);
`endif

    // Single-byte transactions: rs/data, enable window and wait length.
    for (int v = 0; v < 8; v++) begin
      cpu_write(vecs[v].sel, vecs[v].data);
      en_start = -1;
      en_len   = 0;
      idle_e   = -1;
      for (int e = 1; e <= 40; e++) begin
        tick();
        if (e == 1) begin
          check($sformatf("v%0d lcd_rs", v), lcd_rs, vecs[v].sel[0]);
          check($sformatf("v%0d lcd_data", v), lcd_data, vecs[v].data);
        end
        if (lcd_en) begin
          if (en_start < 0) en_start = e;
          en_len++;
        end
        if (!busy && idle_e < 0) idle_e = e;
      end
      check($sformatf("v%0d en_start", v), en_start, vecs[v].en_start);
      check($sformatf("v%0d en_len", v), en_len, vecs[v].en_len);
      check($sformatf("v%0d idle_edge", v), idle_e, vecs[v].idle_edge);
      read_status(st, 1'b0);
      check($sformatf("v%0d status", v), st, 8'h80);
      $display("vec %0d sel=%0d data=0x%02h en_start=%0d en_len=%0d idle=%0d",
               v, vecs[v].sel, vecs[v].data, en_start, en_len, idle_e);
    end

    // Six back-to-back writes: one in flight, four queued, one dropped.
    for (int i = 0; i < 6; i++) cpu_write(2'd1, 8'h10 + 8'(i));
    check("ovf in-flight byte", lcd_data, 8'h10);
    read_status(st, 1'b0);
    check("ovf status set", st, 8'h87);
    read_status(st, 1'b1);
    check("ovf status read", st, 8'h87);
    read_status(st, 1'b0);
    check("ovf status cleared", st, 8'h83);
    collect(300);
    check("ovf byte count", ncap, 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf byte%0d", i + 1), cap[i], 8'h11 + 8'(i));
    $display("overflow sequence: %0d queued bytes replayed", ncap);

    // Full FIFO: push lands on the edge that pops the next byte.
    for (int i = 0; i < 5; i++) cpu_write(2'd1, 8'h20 + 8'(i));
    repeat (10) tick();
    cpu_write(2'd1, 8'h25);
    check("pushpop popped head", lcd_data, 8'h21);
    read_status(st, 1'b1);
    check("pushpop status", st, 8'h83);
    collect(300);
    check("pushpop byte count", ncap, 5);
    for (int i = 0; i < 5; i++) check($sformatf("pushpop byte%0d", i), cap[i], 8'h21 + 8'(i));
    $display("full push+pop sequence: %0d bytes replayed", ncap);

    // Reset in the middle of an enable pulse.
    cpu_write(2'd1, 8'h30);
    cpu_write(2'd1, 8'h31);
    tick();
    tick();
    check("pre-reset lcd_en", lcd_en, 1);
    #2 reset = 1'b0;
    #1;
    check("mid-pulse reset lcd_en", lcd_en, 0);
    check("mid-pulse reset lcd_data", lcd_data, 8'h00);
    check("mid-pulse reset busy", busy, INIT_EN);
    tick();
    reset = 1'b1;
    tick();
    read_status(st, 1'b0);
    check("post-reset status", st, STATUS_AFTER_RESET);
    collect(600);
    check("post-reset pulses", ncap, INIT_EN ? 4 : 0);
    check("post-reset busy", busy, 0);
    $display("reset during pulse: %0d pulses after release", ncap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
